fifo_rd_packer: RTL and testbench

Read-side packer that sits directly downstream of the synchronous FIFO. It pops DIN_W-bit entries through the FIFO's read port, which has one-cycle read latency. It packs RATIO consecutive entries into one wide word and presents that word on a valid/ready output stream. A flush input forces a partially filled word out with a lane-keep mask, so a packet tail is never stranded.

---
 rtl/fifo_pack_pkg.sv | 10 +
 rtl/fifo_rd_packer.sv | 135 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pack_pkg.sv
// Shared types and default sizing for the FIFO read-side packer.
package fifo_pack_pkg;

  localparam int unsigned DIN_W_DEF = 8;
  localparam int unsigned RATIO_DEF = 4;
  localparam int unsigned LANE_W    = $clog2(RATIO_DEF + 1);

  typedef enum logic {FILL, DRAIN} state_e;

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops entries from a one-cycle-latency FIFO read port and packs RATIO of them
// into a wide valid/ready beat; flush emits a partial word with a keep mask.
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int unsigned DIN_W = DIN_W_DEF,
  parameter int unsigned RATIO = RATIO_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DIN_W-1:0]       fifo_dout,
  input  logic                   flush,
  output logic                   flush_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic [15:0]            words_out
);

  localparam int unsigned CNT_W = $clog2(RATIO + 1);
  localparam int unsigned IDX_W = $clog2(RATIO);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               lane_cnt_q, lane_cnt_d;
  logic                           inflight_q;
  logic [RATIO-1:0][DIN_W-1:0]    pack_q, pack_d;
  logic                           out_valid_q, out_valid_d;
  logic [DIN_W*RATIO-1:0]         out_data_q, out_data_d;
  logic [RATIO-1:0]               out_keep_q, out_keep_d;
  logic                           flush_ack_q, flush_ack_d;
  logic [15:0]                    words_q, words_d;
  logic [CNT_W-1:0]               pending;
  logic                           out_free;
  logic                           xfer;
  logic                           drain_done;

  // Lanes already claimed, counting the read whose data lands next cycle.
  assign pending  = lane_cnt_q + CNT_W'(inflight_q);
  assign out_free = !out_valid_q || out_ready;

  // Gated by rst_n so no read strobe escapes while the block is held in reset.
  assign fifo_rd_en = rst_n && (state_q == FILL) && !fifo_empty &&
                      (pending < CNT_W'(RATIO));

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    pack_d      = pack_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    flush_ack_d = 1'b0;
    words_d     = words_q;
    xfer        = 1'b0;
    drain_done  = 1'b0;

    if (out_valid_q && out_ready) begin
      words_d     = words_q + 16'd1;
      out_valid_d = 1'b0;
    end

    if (inflight_q) begin
      pack_d[IDX_W'(lane_cnt_q)] = fifo_dout;
      lane_cnt_d                 = lane_cnt_q + CNT_W'(1);
    end

    case (state_q)
      FILL: begin
        xfer = out_free && (lane_cnt_q == CNT_W'(RATIO));
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q) begin
          if (lane_cnt_q == '0) begin
            drain_done = 1'b1;
          end else if (out_free) begin
            xfer       = 1'b1;
            drain_done = 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase

    if (drain_done) begin
      state_d     = FILL;
      flush_ack_d = 1'b1;
    end

    // Cleared pack lanes guarantee unused lanes of a partial word read as zero.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = pack_q;
      for (int unsigned i = 0; i < RATIO; i++) begin
        out_keep_d[i] = (CNT_W'(i) < lane_cnt_q);
      end
      lane_cnt_d = '0;
      pack_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      lane_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      flush_ack_q <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      inflight_q  <= fifo_rd_en;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      flush_ack_q <= flush_ack_d;
      words_q     <= words_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign flush_ack = flush_ack_q;
  assign words_out = words_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO model plus an in-order scoreboard of popped entries.
module tb_fifo_rd_packer;

  localparam int unsigned DIN_W = 8;
  localparam int unsigned RATIO = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic [DIN_W-1:0]       fifo_dout;
  logic                   flush;
  logic                   flush_ack;
  logic                   out_valid;
  logic                   out_ready;
  logic [DIN_W*RATIO-1:0] out_data;
  logic [RATIO-1:0]       out_keep;
  logic [15:0]            words_out;

  fifo_rd_packer #(.DIN_W(DIN_W), .RATIO(RATIO)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .flush(flush), .flush_ack(flush_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .words_out(words_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DIN_W-1:0] fifo_q[$];
  logic [DIN_W-1:0] popped[$];
  int               tick_n = 0;
  int               rd_pulses, first_rd_tick, first_valid_tick, ack_tick, ack_count, beats;
  logic             allow_partial;
  logic [15:0]      exp_words;
  logic [31:0]      last_data;
  logic [3:0]       last_keep;
  logic             prev_hold;
  logic [31:0]      prev_data;
  logic [3:0]       prev_keep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DIN_W-1:0] d);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // A beat must carry the oldest unconsumed popped entries, lane 0 first.
  task automatic accept_beat();
    int          n;
    logic [31:0] ed;
    logic [3:0]  ek;
    n  = RATIO;
    if (allow_partial && popped.size() < RATIO) n = popped.size();
    ed = '0;
    ek = '0;
    for (int i = 0; i < n; i++) begin
      ek[i] = 1'b1;
      if (i < popped.size()) ed[i*8 +: 8] = popped[i];
    end
    chk("beat_keep", 64'(out_keep), 64'(ek));
    chk("beat_data", 64'(out_data), 64'(ed));
    for (int i = 0; i < n && popped.size() > 0; i++) void'(popped.pop_front());
    exp_words = exp_words + 16'd1;
    beats++;
    last_data = out_data;
    last_keep = out_keep;
  endtask

  task automatic tick();
    logic do_pop;
    @(negedge clk);
    if (!rst_n) begin
      popped.delete();
      exp_words = '0;
      prev_hold = 1'b0;
    end else begin
      chk("words_out", 64'(words_out), 64'(exp_words));
      if (fifo_rd_en) begin
        chk("rd_while_empty", 64'(fifo_empty), 64'(0));
        rd_pulses++;
        if (first_rd_tick < 0) first_rd_tick = tick_n;
      end
      if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'(out_data), 64'(prev_data));
        chk("hold_keep", 64'(out_keep), 64'(prev_keep));
      end
      if (out_valid && first_valid_tick < 0) first_valid_tick = tick_n;
      if (flush_ack) begin
        ack_count++;
        ack_tick = tick_n;
      end
      if (out_valid && out_ready) accept_beat();
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_keep = out_keep;
    end
    do_pop = rst_n && fifo_rd_en && (fifo_q.size() > 0);
    @(posedge clk);
    tick_n++;
    #1;
    if (do_pop) begin
      fifo_dout = fifo_q.pop_front();
      popped.push_back(fifo_dout);
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_until_beats(input string tag, input int target, input int budget);
    int b;
    b = budget;
    while (beats < target && b > 0) begin
      tick();
      b--;
    end
    chk(tag, 64'(beats), 64'(target));
  endtask

  initial begin
    int               t_fl;
    logic [DIN_W-1:0] d[8];
    rst_n = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; flush = 1'b0; out_ready = 1'b0;
    allow_partial = 1'b0; exp_words = '0; beats = 0; rd_pulses = 0;
    first_rd_tick = -1; first_valid_tick = -1; ack_tick = -1; ack_count = 0;
    prev_hold = 1'b0; prev_data = '0; prev_keep = '0; last_data = '0; last_keep = '0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      fifo_empty = 1'($urandom); fifo_dout = 8'($urandom);
      flush = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));
      chk("rst_flush_ack", 64'(flush_ack), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_out_keep", 64'(out_keep), 64'(0));
      chk("rst_words", 64'(words_out), 64'(0));
    end
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; rst_n = 1'b1;

    // Basic pack
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run_until_beats("basic_timeout", beats + 1, 30);
    chk("basic_rd_pulses", 64'(rd_pulses), 64'(4));
    chk("basic_data", 64'(last_data), 64'h44332211);
    chk("basic_keep", 64'(last_keep), 64'hF);
    chk("basic_words", 64'(words_out), 64'(1));
    // valid registers RATIO+1 edges after the edge that samples the first rd_en
    chk("basic_latency", 64'(first_valid_tick - first_rd_tick), 64'(RATIO + 2));

    // Backpressure
    out_ready = 1'b0; rd_pulses = 0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (30) tick();
    chk("bp_rd_pulses", 64'(rd_pulses), 64'(8));
    chk("bp_valid", 64'(out_valid), 64'(1));
    chk("bp_hold_data", 64'(out_data), 64'h04030201);
    out_ready = 1'b1;
    run_until_beats("bp_timeout", beats + 2, 20);
    chk("bp_last_data", 64'(last_data), 64'h08070605);
    chk("bp_words", 64'(words_out), 64'(3));

    // Partial flush
    allow_partial = 1'b1;
    push(8'hAA); push(8'hBB);
    repeat (6) tick();
    first_valid_tick = -1; ack_count = 0;
    flush = 1'b1; t_fl = tick_n;
    tick();
    flush = 1'b0;
    run_until_beats("pf_timeout", beats + 1, 10);
    repeat (3) tick();
    chk("pf_data", 64'(last_data), 64'h0000BBAA);
    chk("pf_keep", 64'(last_keep), 64'h3);
    chk("pf_ack_count", 64'(ack_count), 64'(1));
    chk("pf_ack_with_valid", 64'(ack_tick), 64'(first_valid_tick));
    chk("pf_ack_delay", 64'(ack_tick - t_fl), 64'(2));

    // Empty flush
    first_valid_tick = -1; ack_count = 0;
    flush = 1'b1; t_fl = tick_n;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    chk("ef_ack_count", 64'(ack_count), 64'(1));
    chk("ef_ack_delay", 64'(ack_tick - t_fl), 64'(2));
    chk("ef_no_valid", 64'(first_valid_tick), 64'(-1));
    allow_partial = 1'b0;

    // Reset with three lanes landed and a fourth read in flight
    rd_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = 8'($urandom);
      push(d[i]);
    end
    for (int i = 0; i < 20 && rd_pulses < 4; i++) tick();
    chk("mr_rd_pulses", 64'(rd_pulses), 64'(4));
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("mr_valid", 64'(out_valid), 64'(0));
    chk("mr_words", 64'(words_out), 64'(0));
    run_until_beats("mr_timeout", beats + 1, 30);
    chk("mr_clean_word", 64'(last_data), 64'({d[7], d[6], d[5], d[4]}));
    chk("mr_words_after", 64'(words_out), 64'(1));

    // Random traffic with random backpressure, then a flush to drain the tail
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) push(8'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 200 && fifo_q.size() > 0; i++) tick();
    repeat (10) tick();
    allow_partial = 1'b1; ack_count = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    chk("rnd_ack_count", 64'(ack_count), 64'(1));
    chk("rnd_all_emitted", 64'(popped.size()), 64'(0));
    chk("rnd_words", 64'(words_out), 64'(exp_words));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
